// File: rtl/fp_stream_accumulator.sv
// Streaming FP32 accumulator: sums a batch of valid/ready operands into one total,
// closing on in_last or after N_MAX terms, and holds the result until the sink takes it.
module FloatingPointAdder (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Sum
);
   logic [31:0] x, y;
   logic [7:0]  ex, ey, d;
   logic [26:0] mx, my, r;
   logic [8:0]  er, sh;
   logic [4:0]  lz;
   logic        x_nan, y_nan, x_inf, y_inf, found;

   always_comb begin
      if (A[30:0] >= B[30:0]) begin
         x = A; y = B;
      end else begin
         x = B; y = A;
      end
      // Mantissas carry a spare top bit for the carry and two low bits for alignment.
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {1'b0, x[30:23] != 8'd0, x[22:0], 2'b00};
      my = {1'b0, y[30:23] != 8'd0, y[22:0], 2'b00};
      d  = ex - ey;
      my = (d > 8'd26) ? 27'd0 : (my >> d);
      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      er    = {1'b0, ex};
      r     = '0;
      lz    = '0;
      sh    = '0;
      found = 1'b0;
      Sum   = '0;
      if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
         Sum = 32'h7FC0_0000;
      end else if (x_inf) begin
         Sum = x;
      end else if (x[31] == y[31]) begin
         r = mx + my;
         if (r[26]) begin
            r  = r >> 1;
            er = er + 9'd1;
         end
         if (er >= 9'd255) Sum = {x[31], 8'hFF, 23'd0};
         else              Sum = {x[31], r[25] ? er[7:0] : 8'd0, r[24:2]};
      end else begin
         r = mx - my;
         if (r != 27'd0) begin
            for (int i = 25; i >= 0; i--) begin
               if (!found) begin
                  if (r[i]) found = 1'b1;
                  else      lz = lz + 5'd1;
               end
            end
            // Normalise, but never below the minimum exponent (falls into denormal).
            sh  = ({4'd0, lz} < er) ? {4'd0, lz} : (er - 9'd1);
            r   = r << sh;
            er  = er - sh;
            Sum = {x[31], r[25] ? er[7:0] : 8'd0, r[24:2]};
         end
      end
   end
endmodule

module fp_stream_accumulator #(
   parameter int N_MAX = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             flag_nan,
   output logic             flag_inf
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t           state_q;
   logic [31:0]      acc_q, out_data_q, sum;
   logic [CNT_W-1:0] count_q;
   logic             in_ready_q, out_valid_q, busy_q, nan_q, inf_q;
   logic             accept, nan_d, inf_d;

   FloatingPointAdder u_add (.A(acc_q), .B(in_data), .Sum(sum));

   assign accept = in_valid & in_ready_q;
   assign nan_d  = ((in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0)) ||
                   ((sum[30:23] == 8'hFF) && (sum[22:0] != 23'd0));
   assign inf_d  = ((in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0)) ||
                   ((sum[30:23] == 8'hFF) && (sum[22:0] == 23'd0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         out_data_q  <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         nan_q       <= 1'b0;
         inf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q    <= ACC;
               acc_q      <= '0;
               count_q    <= '0;
               nan_q      <= 1'b0;
               inf_q      <= 1'b0;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b1;
            end
            ACC: if (start) begin
               acc_q   <= '0;
               count_q <= '0;
               nan_q   <= 1'b0;
               inf_q   <= 1'b0;
            end else if (accept) begin
               acc_q   <= sum;
               count_q <= count_q + 1'b1;
               nan_q   <= nan_q | nan_d;
               inf_q   <= inf_q | inf_d;
               if (in_last || (count_q == CNT_W'(N_MAX - 1))) begin
                  state_q     <= HOLD;
                  out_data_q  <= sum;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            HOLD: if (out_ready) begin
               out_valid_q <= 1'b0;
               if (start) begin
                  state_q    <= ACC;
                  acc_q      <= '0;
                  count_q    <= '0;
                  nan_q      <= 1'b0;
                  inf_q      <= 1'b0;
                  in_ready_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign count     = count_q;
   assign busy      = busy_q;
   assign flag_nan  = nan_q;
   assign flag_inf  = inf_q;
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator; expected batch results are queued by the
// stimulus and popped by an independent monitor on each output handshake.
module tb_fp_stream_accumulator;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid, busy, flag_nan, flag_inf;
   logic [31:0] out_data;
   logic [4:0]  count;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  cnt;
      logic        nan;
      logic        inf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, failures = 0;

   fp_stream_accumulator #(.N_MAX(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .count(count), .busy(busy), .flag_nan(flag_nan),
      .flag_inf(flag_inf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      cyc();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got %h with no expectation queued", out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_data", out_data, e.data);
            check("mon_count", 32'(count), 32'(e.cnt));
            check("mon_nan", 32'(flag_nan), 32'(e.nan));
            check("mon_inf", 32'(flag_inf), 32'(e.inf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_count", 32'(count), 32'd0);
      cyc();
      rst = 1'b0;
      cyc();
      check("idle_in_ready", 32'(in_ready), 32'd0);

      // 1: 1+2+3 back-to-back
      out_ready = 1'b1;
      exp_q.push_back('{32'h40C0_0000, 5'd3, 1'b0, 1'b0});
      pulse_start();
      check("t1_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data = 32'h3F80_0000; cyc();
      in_data = 32'h4000_0000; cyc();
      in_data = 32'h4040_0000; in_last = 1'b1; cyc();
      in_valid = 1'b0; in_last = 1'b0;
      check("t1_out_valid_latency", 32'(out_valid), 32'd1);
      cyc();
      check("t1_back_idle", 32'(busy), 32'd0);

      // 2: result held while the sink stalls
      out_ready = 1'b0;
      exp_q.push_back('{32'h40C0_0000, 5'd3, 1'b0, 1'b0});
      pulse_start();
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b1);
      in_valid = 1'b1; in_data = 32'h3F80_0000;
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 32'(out_valid), 32'd1);
         check("t2_hold_data", out_data, 32'h40C0_0000);
         check("t2_hold_count", 32'(count), 32'd3);
         check("t2_hold_in_ready", 32'(in_ready), 32'd0);
         start = (i == 2);
         cyc();
      end
      start = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1;
      cyc();
      check("t2_idle_busy", 32'(busy), 32'd0);
      check("t2_idle_valid", 32'(out_valid), 32'd0);

      // 3: automatic close on the 16th term
      out_ready = 1'b0;
      exp_q.push_back('{32'h4180_0000, 5'd16, 1'b0, 1'b0});
      pulse_start();
      for (int i = 0; i < 16; i++) send(32'h3F80_0000, 1'b0);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      cyc();

      // 4: NaN then Inf flags, cleared by a new start
      exp_q.push_back('{32'h7FC0_0000, 5'd2, 1'b1, 1'b0});
      pulse_start();
      send(32'h7FC0_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      check("t4_nan_flag", 32'(flag_nan), 32'd1);
      cyc();
      exp_q.push_back('{32'h7F80_0000, 5'd1, 1'b0, 1'b1});
      pulse_start();
      check("t4_nan_cleared", 32'(flag_nan), 32'd0);
      send(32'h7F80_0000, 1'b1);
      check("t4_inf_flag", 32'(flag_inf), 32'd1);
      cyc();

      // 5: gapped input, restart mid-batch
      exp_q.push_back('{32'h4000_0000, 5'd1, 1'b0, 1'b0});
      pulse_start();
      send(32'h3F80_0000, 1'b0);
      cyc();
      in_last = 1'b1; cyc(); in_last = 1'b0;
      send(32'h3F80_0000, 1'b0);
      cyc();
      check("t5_count_two", 32'(count), 32'd2);
      pulse_start();
      check("t5_count_cleared", 32'(count), 32'd0);
      check("t5_still_busy", 32'(busy), 32'd1);
      cyc();
      send(32'h4000_0000, 1'b1);
      cyc();

      // 6: asynchronous reset mid-batch
      pulse_start();
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_out_data", out_data, 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd0);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      cyc();
      rst = 1'b0;
      in_valid = 1'b1; in_last = 1'b1; in_data = 32'h3F80_0000;
      for (int i = 0; i < 3; i++) cyc();
      in_valid = 1'b0; in_last = 1'b0;
      check("t6_post_busy", 32'(busy), 32'd0);
      check("t6_post_count", 32'(count), 32'd0);
      check("t6_post_valid", 32'(out_valid), 32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
